// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I core family.
// Widths, reset PC and the fetch-queue entry layout live here.
package rv_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;
   localparam int unsigned INST_W       = 32;
   localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = '0;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [INST_W-1:0]       inst;
   } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries ahead of decode.
// A flush empties it and takes priority over push and pop in the same cycle.
module inst_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   input  logic                       flush,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/fetch_unit.sv
// Credit-limited in-order instruction prefetcher between imem and decode.
// Tracks outstanding requests and discards stale responses after a redirect.
module fetch_unit
   import rv_pkg::*;
#(
   parameter int unsigned     XLEN     = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
   parameter int unsigned     DEPTH    = 4
) (
   input  logic              clk,
   input  logic              reset,
   output logic [XLEN-1:0]   op_inst_addr,
   output logic              op_inst_rd,
   input  logic              ip_inst_valid,
   input  logic [INST_W-1:0] ip_inst_from_imem,
   input  logic              ip_redirect,
   input  logic [XLEN-1:0]   ip_redirect_pc,
   output logic              op_inst_valid,
   output logic [INST_W-1:0] op_inst,
   output logic [XLEN-1:0]   op_inst_pc,
   input  logic              ip_inst_ready
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [INST_W-1:0] inst;
   } entry_t;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [XLEN-1:0] target_pc;
   logic [CW-1:0]   pending_q, pending_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [CW-1:0]   fifo_count;
   logic [CW:0]     credit_used;
   logic            issue, discard;
   logic            fifo_push, fifo_pop, fifo_empty, fifo_full;
   entry_t          push_entry, head_entry;

   assign target_pc   = {ip_redirect_pc[XLEN-1:2], 2'b00};
   assign credit_used = {1'b0, pending_q} + {1'b0, fifo_count};
   assign issue       = !reset && !ip_redirect && (credit_used < CREDIT_MAX);
   // A response landing in a redirect cycle belongs to the old stream.
   assign discard     = ip_inst_valid && (ip_redirect || (drop_q != '0));
   assign fifo_push   = ip_inst_valid && !discard;
   assign fifo_pop    = op_inst_valid && ip_inst_ready;
   assign push_entry  = '{pc: resp_pc_q, inst: ip_inst_from_imem};

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      drop_d     = drop_q;
      pending_d  = pending_q + CW'(issue) - CW'(ip_inst_valid);
      if (ip_inst_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (fifo_push) resp_pc_d = resp_pc_q + XLEN'(4);
      if (issue) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (ip_redirect) begin
         fetch_pc_d = target_pc;
         resp_pc_d  = target_pc;
         drop_d     = pending_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         pending_q  <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         pending_q  <= pending_d;
         drop_q     <= drop_d;
      end
   end

   inst_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_inst_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .wdata (push_entry),
      .pop   (fifo_pop),
      .flush (ip_redirect),
      .rdata (head_entry),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign op_inst_rd    = issue;
   assign op_inst_addr  = fetch_pc_q;
   assign op_inst_valid = !fifo_empty;
   assign op_inst       = fifo_empty ? '0 : head_entry.inst;
   assign op_inst_pc    = fifo_empty ? resp_pc_q : head_entry.pc;

   resp_needs_request: assert property (
      @(posedge clk) disable iff (reset) ip_inst_valid |-> (pending_q != '0));
   no_fifo_overflow: assert property (
      @(posedge clk) disable iff (reset) !(fifo_push && fifo_full && !fifo_pop && !ip_redirect));
   drop_within_pending: assert property (
      @(posedge clk) disable iff (reset) drop_q <= pending_q);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based model of requests/responses and a fixed-latency imem.
// Directed scenarios with literal expectations on top of per-cycle model comparison.
module tb_fetch_unit;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic        clk, reset;
   logic [31:0] op_inst_addr, op_inst, op_inst_pc;
   logic        op_inst_rd, op_inst_valid;
   logic        ip_inst_valid, ip_redirect, ip_inst_ready;
   logic [31:0] ip_inst_from_imem, ip_redirect_pc;

   fetch_unit #(
      .XLEN     (XLEN),
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .op_inst_addr      (op_inst_addr),
      .op_inst_rd        (op_inst_rd),
      .ip_inst_valid     (ip_inst_valid),
      .ip_inst_from_imem (ip_inst_from_imem),
      .ip_redirect       (ip_redirect),
      .ip_redirect_pc    (ip_redirect_pc),
      .op_inst_valid     (op_inst_valid),
      .op_inst           (op_inst),
      .op_inst_pc        (op_inst_pc),
      .ip_inst_ready     (ip_inst_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct { logic [31:0] addr; bit stale; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
   typedef struct { logic [31:0] addr; int due; } mreq_t;

   req_t        m_out[$];
   ent_t        m_fifo[$];
   logic [31:0] m_fetch;
   mreq_t       memq[$];
   logic [31:0] issued[$];
   logic [31:0] delivered[$];
   bit          hist_valid[256];
   logic [31:0] hist_pc[256];
   int          lat, cyc, n_checks, n_pass;
   logic        ready_v;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h0013_5700;
   endfunction

   function automatic logic [31:0] iss_at(input int i);
      return (i < issued.size()) ? issued[i] : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] del_at(input int i);
      return (i < delivered.size()) ? delivered[i] : 32'hFFFF_FFFF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ip_inst_valid = 1'b0;
      ip_redirect = 1'b0;
      #1;
      chk("rst_rd", 32'(op_inst_rd), 32'd0);
      chk("rst_valid", 32'(op_inst_valid), 32'd0);
      chk("rst_inst", op_inst, 32'd0);
      chk("rst_pc", op_inst_pc, RESET_PC);
      chk("rst_addr", op_inst_addr, RESET_PC);
      memq.delete();
      m_out.delete();
      m_fifo.delete();
      m_fetch = RESET_PC;
      issued.delete();
      delivered.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc = 0;
   endtask

   // One clock cycle: drive inputs, compare against the model at negedge, advance the model.
   task automatic cycle(input logic redir, input logic [31:0] rpc);
      logic        mv, exp_rd;
      logic [31:0] ma;
      req_t        r;
      mv = 1'b0;
      ma = '0;
      if (memq.size() > 0 && memq[0].due == cyc) begin
         mv = 1'b1;
         ma = memq[0].addr;
         memq.delete(0);
      end
      ip_redirect = redir;
      ip_redirect_pc = rpc;
      ip_inst_ready = ready_v;
      ip_inst_valid = mv;
      ip_inst_from_imem = mv ? mem_word(ma) : 32'hDEAD_BEEF;
      @(negedge clk);
      exp_rd = !redir && (m_out.size() + m_fifo.size() < DEPTH);
      chk("rd", 32'(op_inst_rd), 32'(exp_rd));
      chk("addr", op_inst_addr, m_fetch);
      chk("valid", 32'(op_inst_valid), 32'(m_fifo.size() > 0));
      if (m_fifo.size() > 0) begin
         chk("inst", op_inst, m_fifo[0].inst);
         chk("pc", op_inst_pc, m_fifo[0].pc);
      end
      if (cyc < 256) begin
         hist_valid[cyc] = op_inst_valid;
         hist_pc[cyc] = op_inst_pc;
      end
      if (op_inst_rd) begin
         issued.push_back(op_inst_addr);
         memq.push_back('{addr: op_inst_addr, due: cyc + lat});
      end
      if (op_inst_valid && ready_v && !redir) delivered.push_back(op_inst_pc);
      if (redir) begin
         m_fifo.delete();
         if (mv && m_out.size() > 0) m_out.delete(0);
         foreach (m_out[i]) m_out[i].stale = 1'b1;
         m_fetch = {rpc[31:2], 2'b00};
      end else begin
         if (m_fifo.size() > 0 && ready_v) m_fifo.delete(0);
         if (mv && m_out.size() > 0) begin
            r = m_out[0];
            m_out.delete(0);
            if (!r.stale) m_fifo.push_back('{pc: r.addr, inst: mem_word(ma)});
         end
         if (exp_rd) begin
            m_out.push_back('{addr: m_fetch, stale: 1'b0});
            m_fetch = m_fetch + 32'd4;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 32'h0);
   endtask

   initial begin
      bit found;
      n_checks = 0;
      n_pass = 0;
      cyc = 0;
      reset = 1'b0;
      ip_inst_valid = 1'b0;
      ip_redirect = 1'b0;
      ip_redirect_pc = '0;
      ip_inst_ready = 1'b0;
      ip_inst_from_imem = '0;
      #1;

      // Streaming with 1-cycle memory
      lat = 1;
      ready_v = 1'b1;
      do_reset();
      run(8);
      chk("t1_req0", iss_at(0), 32'h0);
      chk("t1_req1", iss_at(1), 32'h4);
      chk("t1_req2", iss_at(2), 32'h8);
      chk("t1_valid_c1", 32'(hist_valid[1]), 32'd0);
      chk("t1_valid_c2", 32'(hist_valid[2]), 32'd1);
      chk("t1_pc_c2", hist_pc[2], 32'h0);
      chk("t1_pc_c3", hist_pc[3], 32'h4);
      chk("t1_pc_c4", hist_pc[4], 32'h8);

      // Credit limit with decode stalled
      ready_v = 1'b0;
      do_reset();
      run(8);
      chk("t2_req_count", 32'(issued.size()), 32'd4);
      chk("t2_req3", iss_at(3), 32'hC);
      ready_v = 1'b1;
      run(3);
      chk("t2_first_pop", del_at(0), 32'h0);
      chk("t2_req_after", iss_at(4), 32'h10);

      // Redirect with two requests in flight, 3-cycle memory
      lat = 3;
      do_reset();
      run(2);
      cycle(1'b1, 32'h103);
      run(12);
      chk("t3_req_target", iss_at(2), 32'h100);
      chk("t3_pc0", del_at(0), 32'h100);
      chk("t3_pc1", del_at(1), 32'h104);

      // Redirect coinciding with a response and a pop
      do_reset();
      run(3);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (memq.size() > 0 && memq[0].due == cyc && m_fifo.size() > 0) found = 1'b1;
         else run(1);
      end
      chk("t4_found_slot", 32'(found), 32'd1);
      cycle(1'b1, 32'h200);
      delivered.delete();
      chk("t4_empty_after", 32'(op_inst_valid), 32'd0);
      run(12);
      chk("t4_pc0", del_at(0), 32'h200);
      chk("t4_pc1", del_at(1), 32'h204);

      // Address wrap at the top of the space
      lat = 1;
      do_reset();
      cycle(1'b1, 32'hFFFF_FFFE);
      run(6);
      chk("t5_req0", iss_at(0), 32'hFFFF_FFFC);
      chk("t5_req1", iss_at(1), 32'h0);
      chk("t5_valid_r2", 32'(hist_valid[2]), 32'd0);
      chk("t5_valid_r3", 32'(hist_valid[3]), 32'd1);
      chk("t5_pc0", del_at(0), 32'hFFFF_FFFC);
      chk("t5_pc1", del_at(1), 32'h0);

      // Asynchronous reset mid-stream with three responses outstanding
      lat = 3;
      ready_v = 1'b0;
      do_reset();
      run(4);
      chk("t6_pre_valid", 32'(op_inst_valid), 32'd1);
      chk("t6_pre_addr", op_inst_addr, 32'h10);
      lat = 1;
      ready_v = 1'b1;
      do_reset();
      run(8);
      chk("t6_req0", iss_at(0), RESET_PC);
      chk("t6_pc0", del_at(0), RESET_PC);
      chk("t6_pc1", del_at(1), RESET_PC + 32'd4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
